// File: rtl/move_validator.sv
// -----------------------------------------------------------------------------
// move_validator
//
// Purpose:
//   Accepts or refuses piece drops into a column-stacking game board (Connect-4
//   style). It keeps a height counter per column and a turn bit. It reports
//   each accepted drop (column, landing row, player) or each refused request
//   with a one-cycle registered pulse.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   synchronous, active-low reset
//   enter_input    in   drop request level; only a 0->1 transition is an event
//   column_select  in   [COLS] one-hot column request, sampled at the event edge
//   clear_board    in   synchronous board clear, wins over a simultaneous event
//   move_valid     out  one-cycle pulse, drop accepted
//   move_reject    out  one-cycle pulse, request refused
//   move_col       out  [CW] column index of the last accepted drop
//   move_row       out  [RW] landing row of the last accepted drop (0 = bottom)
//   move_player    out  player who made the last accepted drop
//   player         out  player whose turn it is now
//   column_full    out  [COLS] bit i set when column i holds ROWS pieces
//   board_full     out  all columns full
// -----------------------------------------------------------------------------
module move_validator #(
    parameter int COLS = 7,
    parameter int ROWS = 6,
    localparam int CW  = $clog2(COLS),
    localparam int RW  = $clog2(ROWS),
    localparam int HW  = $clog2(ROWS + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enter_input,
    input  logic [COLS-1:0] column_select,
    input  logic            clear_board,
    output logic            move_valid,
    output logic            move_reject,
    output logic [CW-1:0]   move_col,
    output logic [RW-1:0]   move_row,
    output logic            move_player,
    output logic            player,
    output logic [COLS-1:0] column_full,
    output logic            board_full
);

    localparam logic [HW-1:0] ROWS_H = HW'(ROWS);

    // State registers
    logic [HW-1:0] height_q [COLS];
    logic [HW-1:0] height_d [COLS];
    logic          player_q,      player_d;
    logic          enter_prev_q,  enter_prev_d;
    logic          move_valid_q,  move_valid_d;
    logic          move_reject_q, move_reject_d;
    logic [CW-1:0] move_col_q,    move_col_d;
    logic [RW-1:0] move_row_q,    move_row_d;
    logic          move_player_q, move_player_d;

    // Request decode
    logic          req_event;
    logic          sel_onehot;
    logic [CW-1:0] sel_idx;
    logic [HW-1:0] sel_height;
    logic          req_legal;

    always_comb begin
        // x & (x-1) clears the lowest set bit; zero result means at most one bit set
        sel_onehot = (|column_select) &&
                     ((column_select & (column_select - COLS'(1))) == '0);
        sel_idx    = '0;
        sel_height = '0;
        // OR-merge of heights is only meaningful when the select is one-hot,
        // which req_legal requires anyway
        for (int i = 0; i < COLS; i++) begin
            if (column_select[i]) begin
                sel_idx    = CW'(i);
                sel_height = sel_height | height_q[i];
            end
        end
        req_event = enter_input & ~enter_prev_q;
        req_legal = sel_onehot && (sel_height < ROWS_H);
    end

    // Next-state logic
    always_comb begin
        for (int i = 0; i < COLS; i++) begin
            height_d[i] = height_q[i];
        end
        player_d      = player_q;
        enter_prev_d  = enter_input;
        move_valid_d  = 1'b0;
        move_reject_d = 1'b0;
        move_col_d    = move_col_q;
        move_row_d    = move_row_q;
        move_player_d = move_player_q;

        if (clear_board) begin
            // A simultaneous request is discarded; enter_prev still tracks input
            for (int i = 0; i < COLS; i++) begin
                height_d[i] = '0;
            end
            player_d = 1'b0;
        end else if (req_event) begin
            if (req_legal) begin
                move_valid_d  = 1'b1;
                move_col_d    = sel_idx;
                move_row_d    = RW'(sel_height);
                move_player_d = player_q;
                player_d      = ~player_q;
                for (int i = 0; i < COLS; i++) begin
                    // Saturating increment: a full column never wraps
                    if (column_select[i] && (height_q[i] != ROWS_H)) begin
                        height_d[i] = height_q[i] + HW'(1);
                    end
                end
            end else begin
                move_reject_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < COLS; i++) begin
                height_q[i] <= '0;
            end
            player_q      <= 1'b0;
            // Loading 1 masks an enter held high through reset release
            enter_prev_q  <= 1'b1;
            move_valid_q  <= 1'b0;
            move_reject_q <= 1'b0;
            move_col_q    <= '0;
            move_row_q    <= '0;
            move_player_q <= 1'b0;
        end else begin
            for (int i = 0; i < COLS; i++) begin
                height_q[i] <= height_d[i];
            end
            player_q      <= player_d;
            enter_prev_q  <= enter_prev_d;
            move_valid_q  <= move_valid_d;
            move_reject_q <= move_reject_d;
            move_col_q    <= move_col_d;
            move_row_q    <= move_row_d;
            move_player_q <= move_player_d;
        end
    end

    // Fullness flags come straight from the counters so they rise together
    // with the move_valid pulse of the filling drop
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_full
            assign column_full[gi] = (height_q[gi] == ROWS_H);
        end
    endgenerate

    assign board_full  = &column_full;
    assign move_valid  = move_valid_q;
    assign move_reject = move_reject_q;
    assign move_col    = move_col_q;
    assign move_row    = move_row_q;
    assign move_player = move_player_q;
    assign player      = player_q;

endmodule

// File: tb/tb_move_validator.sv
// -----------------------------------------------------------------------------
// tb_move_validator
//
// Directed bench for move_validator with the default 7x6 board. Inputs are
// driven 1 ns after the rising edge, outputs sampled 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_move_validator;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    logic            clk;
    logic            reset;
    logic            enter_input;
    logic [COLS-1:0] column_select;
    logic            clear_board;
    logic            move_valid;
    logic            move_reject;
    logic [2:0]      move_col;
    logic [2:0]      move_row;
    logic            move_player;
    logic            player;
    logic [COLS-1:0] column_full;
    logic            board_full;

    int errors = 0;
    int checks = 0;

    move_validator #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk           (clk),
        .reset         (reset),
        .enter_input   (enter_input),
        .column_select (column_select),
        .clear_board   (clear_board),
        .move_valid    (move_valid),
        .move_reject   (move_reject),
        .move_col      (move_col),
        .move_row      (move_row),
        .move_player   (move_player),
        .player        (player),
        .column_full   (column_full),
        .board_full    (board_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One drop request: enter high for one edge, then low for two edges.
    // Checks the pulse and the move fields in the cycle after the event edge,
    // then that both pulses are gone the following cycle.
    task automatic drop(input string tag, input logic [COLS-1:0] sel, input logic exp_v,
                        input int exp_col, input int exp_row, input logic exp_mp,
                        input logic exp_pl, input logic [COLS-1:0] exp_cfull);
        column_select = sel;
        enter_input   = 1'b1;
        tick();
        check_eq({tag, ".valid"},  32'(move_valid),  32'(exp_v));
        check_eq({tag, ".reject"}, 32'(move_reject), 32'(!exp_v));
        check_eq({tag, ".col"},    32'(move_col),    32'(exp_col));
        check_eq({tag, ".row"},    32'(move_row),    32'(exp_row));
        check_eq({tag, ".mplayer"},32'(move_player), 32'(exp_mp));
        check_eq({tag, ".player"}, 32'(player),      32'(exp_pl));
        check_eq({tag, ".cfull"},  32'(column_full), 32'(exp_cfull));
        check_eq({tag, ".bfull"},  32'(board_full),  32'(exp_cfull == 7'h7f));
        enter_input = 1'b0;
        tick();
        check_eq({tag, ".pulse_end"}, 32'({move_valid, move_reject}), 32'd0);
        tick();
        $display("drop %s sel=%b valid=%0d reject=%0d col=%0d row=%0d mp=%0d player=%0d",
                 tag, sel, exp_v, !exp_v, exp_col, exp_row, exp_mp, exp_pl);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".valid"},  32'(move_valid),  32'd0);
        check_eq({tag, ".reject"}, 32'(move_reject), 32'd0);
        check_eq({tag, ".col"},    32'(move_col),    32'd0);
        check_eq({tag, ".row"},    32'(move_row),    32'd0);
        check_eq({tag, ".mplayer"},32'(move_player), 32'd0);
        check_eq({tag, ".player"}, 32'(player),      32'd0);
        check_eq({tag, ".cfull"},  32'(column_full), 32'd0);
        check_eq({tag, ".bfull"},  32'(board_full),  32'd0);
    endtask

    initial begin
        int pulses;
        int n;
        logic [COLS-1:0] cf;

        reset         = 1'b0;
        enter_input   = 1'b1;   // held through reset release
        column_select = 7'b0000001;
        clear_board   = 1'b0;
        tick();
        tick();
        check_reset_state("reset");

        // Enter held across reset release must not produce an event
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(move_valid) + int'(move_reject);
        end
        check_eq("held_after_reset.pulses", 32'(pulses), 32'd0);
        enter_input = 1'b0;
        tick();

        // First legal drop into column 5
        drop("c5", 7'b0100000, 1'b1, 5, 0, 1'b0, 1'b1, 7'b0000000);

        // Two bits set, then no bits: both refused, fields retained
        drop("two_bits", 7'b0000101, 1'b0, 5, 0, 1'b0, 1'b1, 7'b0000000);
        drop("no_bits",  7'b0000000, 1'b0, 5, 0, 1'b0, 1'b1, 7'b0000000);

        // Select changes without an enter edge have no effect
        column_select = 7'b0000010;
        tick();
        column_select = 7'b0001000;
        tick();
        check_eq("sel_idle.pulses", 32'({move_valid, move_reject}), 32'd0);
        check_eq("sel_idle.player", 32'(player), 32'd1);

        // Fill column 0 (player starts at 1), then one more is refused
        for (int k = 0; k < ROWS; k++) begin
            drop($sformatf("c0_r%0d", k), 7'b0000001, 1'b1, 0, k,
                 1'((k + 1) & 1), 1'(k & 1), (k == ROWS - 1) ? 7'b0000001 : 7'b0000000);
        end
        drop("c0_over", 7'b0000001, 1'b0, 0, 5, 1'b0, 1'b1, 7'b0000001);

        // Enter held high for 20 cycles: exactly one accepted move
        column_select = 7'b0000010;
        enter_input   = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pulses += int'(move_valid);
        end
        enter_input = 1'b0;
        tick();
        check_eq("hold20.pulses", 32'(pulses), 32'd1);
        check_eq("hold20.col",    32'(move_col), 32'd1);
        check_eq("hold20.player", 32'(player),   32'd0);
        tick();

        // Enter rising on the same edge as clear_board: discarded, board cleared
        column_select = 7'b0000100;
        enter_input   = 1'b1;
        clear_board   = 1'b1;
        tick();
        check_eq("clear.pulses", 32'({move_valid, move_reject}), 32'd0);
        check_eq("clear.player", 32'(player),      32'd0);
        check_eq("clear.cfull",  32'(column_full), 32'd0);
        clear_board = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(move_valid) + int'(move_reject);
        end
        check_eq("clear_held.pulses", 32'(pulses), 32'd0);
        enter_input = 1'b0;
        tick();

        // Column 0 was cleared: the next drop there lands in row 0, player 0
        drop("after_clear", 7'b0000001, 1'b1, 0, 0, 1'b0, 1'b1, 7'b0000000);
        clear_board = 1'b1;
        tick();
        clear_board = 1'b0;
        tick();

        // Fill all 42 slots column by column
        n = 0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                cf = 7'((1 << c) - 1);
                if (r == ROWS - 1) cf = cf | 7'(1 << c);
                drop($sformatf("fill_c%0d_r%0d", c, r), 7'(1 << c), 1'b1, c, r,
                     1'(n & 1), 1'((n + 1) & 1), cf);
                n++;
            end
        end
        drop("full_board", 7'b0001000, 1'b0, 6, 5, 1'b1, 1'b0, 7'b1111111);

        // One-cycle reset mid-game returns everything to reset values
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset_state("reset_midgame");
        tick();
        drop("post_reset", 7'b1000000, 1'b1, 6, 0, 1'b0, 1'b1, 7'b0000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
